// File: rtl/mont_from_domain.sv
// rtl/mont_from_domain.sv - word-serial Montgomery reduction out of the Montgomery domain
module mont_from_domain #(
  parameter int WIDTH  = 1024,
  parameter int NWORDS = WIDTH / 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] n,
  input  logic [31:0]      n0prime,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              CW   = $clog2(NWORDS + 1);
  localparam logic [CW-1:0]   LAST = CW'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC_M,
    ACCUM,
    FINAL_SUB,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [WIDTH+32:0] acc;
  logic [WIDTH-1:0]  n_r;
  logic [31:0]       n0_r;
  logic [31:0]       m;
  logic [CW-1:0]     cnt;
  logic [WIDTH+32:0] n_ext;
  logic [WIDTH+32:0] sum;

  // acc + m*n_r always has a zero low word, so the shift by 32 is exact.
  assign n_ext = {33'b0, n_r};
  assign sum   = acc + n_ext * {{(WIDTH + 1){1'b0}}, m};

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and status outputs; start is only honoured in IDLE.
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = CALC_M;
      end
      CALC_M:    state_nx = ACCUM;
      ACCUM:     state_nx = (cnt == LAST) ? FINAL_SUB : CALC_M;
      FINAL_SUB: state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: one 32-bit quotient digit per CALC_M/ACCUM pair, then a conditional subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      n_r    <= '0;
      n0_r   <= '0;
      m      <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc  <= {33'b0, a};
            n_r  <= n;
            n0_r <= n0prime;
            cnt  <= '0;
          end
        end
        CALC_M: begin
          m <= acc[31:0] * n0_r;
        end
        ACCUM: begin
          acc <= sum >> 32;
          cnt <= cnt + CW'(1);
        end
        FINAL_SUB: begin
          if (acc >= n_ext) begin
            result <= WIDTH'(acc - n_ext);
          end else begin
            result <= WIDTH'(acc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
